// File: rtl/imem_fetch_responder_if.sv
// rtl/imem_fetch_responder_if.sv - fetch request/response channel between fetch stage and imem responder
interface imem_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [79:0] rsp_instruct;
  logic        rsp_mem_err;

  modport master (
    output req_valid,
    output req_pc,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instruct,
    input  rsp_mem_err
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instruct,
    output rsp_mem_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - byte-wide program memory returning a ten-byte instruction window per fetch
module imem_fetch_responder #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [63:0]           load_addr,
  input  logic [7:0]            load_data,
  imem_fetch_responder_if.slave bus
);
  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] base_q, base_d;
  logic [3:0]  idx_q, idx_d;
  logic [79:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic [7:0]  mem [MEM_BYTES];

  logic [64:0] rd_addr;
  logic        rd_in_range;
  logic [7:0]  rd_byte;
  logic [6:0]  rd_shamt;
  logic        load_ok;

  // Program memory is never reset; loads beyond the array are dropped.
  assign load_ok = load_addr < 64'(MEM_BYTES);

  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_addr[AW-1:0]] <= load_data;
    end
  end

  // 65-bit sum so a PC near 2^64 reads as out of range instead of wrapping.
  assign rd_addr     = {1'b0, base_q} + {61'd0, idx_q};
  assign rd_in_range = rd_addr < 65'(MEM_BYTES);
  assign rd_byte     = rd_in_range ? mem[rd_addr[AW-1:0]] : 8'h00;
  assign rd_shamt    = {4'd9 - idx_q, 3'b000};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          base_d  = bus.req_pc;
          idx_d   = 4'd0;
          instr_d = 80'd0;
          err_d   = 1'b0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        instr_d = instr_q | (80'(rd_byte) << rd_shamt);
        if (!rd_in_range) begin
          err_d = 1'b1;
        end
        if (idx_q == 4'd9) begin
          idx_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= 64'd0;
      idx_q   <= 4'd0;
      instr_q <= 80'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready    = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid    = (state_q == ST_RESP);
  assign bus.rsp_instruct = instr_q;
  assign bus.rsp_mem_err  = err_q;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - self-checking bench for imem_fetch_responder
module tb_imem_fetch_responder;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [63:0] load_addr;
  logic [7:0]  load_data;

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         acc_cyc = 0;
  logic [7:0] ref_mem [MEM_BYTES];

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: walk the ten addresses in wide arithmetic; anything at or past the end reads zero.
  function automatic logic [80:0] model(input logic [63:0] pc);
    logic [79:0] w;
    logic        e;
    logic [64:0] a;
    w = '0;
    e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = {1'b0, pc} + 65'(i);
      if (a >= 65'(MEM_BYTES)) begin
        e = 1'b1;
        w = {w[71:0], 8'h00};
      end else begin
        w = {w[71:0], ref_mem[a[9:0]]};
      end
    end
    return {e, w};
  endfunction

  task automatic load_byte(input logic [63:0] addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick;
    load_en = 1'b0;
    if (addr < 64'(MEM_BYTES)) ref_mem[addr[9:0]] = data;
  endtask

  task automatic accept(input logic [63:0] pc);
    int n;
    n = 0;
    bus.req_pc    = pc;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check_eq("req_ready_wait", 80'(bus.req_ready), 80'd1);
    tick;
    acc_cyc       = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    lat = cyc - acc_cyc;
    check_eq({tag, "_latency"}, 80'(lat), 80'd10);
  endtask

  task automatic complete(input string tag);
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 80'(bus.rsp_valid), 80'd0);
    check_eq({tag, "_ready_back"}, 80'(bus.req_ready), 80'd1);
  endtask

  task automatic fetch(input string tag, input logic [63:0] pc, input logic [79:0] exp_w,
                       input logic exp_e, input int stall, input logic pulse);
    int lat;
    accept(pc);
    wait_rsp(tag, lat);
    check_eq({tag, "_instr"}, bus.rsp_instruct, exp_w);
    check_eq({tag, "_err"}, 80'(bus.rsp_mem_err), 80'(exp_e));
    for (int s = 0; s < stall; s++) begin
      if (pulse && s == 1) begin
        bus.req_pc    = 64'd60;
        bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
      end
      tick;
      check_eq({tag, "_hold_instr"}, bus.rsp_instruct, exp_w);
      check_eq({tag, "_hold_valid"}, 80'(bus.rsp_valid), 80'd1);
      check_eq({tag, "_hold_ready"}, 80'(bus.req_ready), 80'd0);
    end
    bus.req_valid = 1'b0;
    complete(tag);
  endtask

  initial begin
    logic [80:0] m;
    logic [63:0] pc;
    int          lat;
    int          seen;
    logic [7:0]  init_bytes [12];
    init_bytes = '{8'h61, 8'h23, 8'h20, 8'h34, 8'h85, 8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

    rst_n         = 1'b0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.rsp_ready = 1'b0;
    #2;
    check_eq("rst_valid", 80'(bus.rsp_valid), 80'd0);
    check_eq("rst_ready", 80'(bus.req_ready), 80'd0);
    check_eq("rst_instr", bus.rsp_instruct, 80'd0);
    check_eq("rst_err", 80'(bus.rsp_mem_err), 80'd0);
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 80'(bus.req_ready), 80'd1);

    for (int i = 0; i < 12; i++) load_byte(64'(62 + i), init_bytes[i]);
    load_byte(64'd1086, 8'hEE);
    fetch("basic", 64'd62, 80'h61232034855300000000, 1'b0, 0, 1'b0);
    fetch("bp", 64'd62, 80'h61232034855300000000, 1'b0, 5, 1'b1);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    check_eq("bp_pc60_ignored", 80'(seen), 80'd0);

    load_byte(64'd1020, 8'hAA);
    load_byte(64'd1021, 8'hBB);
    load_byte(64'd1022, 8'hCC);
    load_byte(64'd1023, 8'hDD);
    fetch("edge", 64'd1020, 80'hAABBCCDD000000000000, 1'b1, 1, 1'b0);

    load_byte(64'd0, 8'h11);
    load_byte(64'd1, 8'h22);
    load_byte(64'd2, 8'h33);
    load_byte(64'd3, 8'h44);
    fetch("ovf", 64'hFFFF_FFFF_FFFF_FFFA, 80'd0, 1'b1, 0, 1'b0);

    accept(64'd62);
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 80'(bus.rsp_valid), 80'd0);
    check_eq("midrst_instr", bus.rsp_instruct, 80'd0);
    check_eq("midrst_err", 80'(bus.rsp_mem_err), 80'd0);
    check_eq("midrst_ready", 80'(bus.req_ready), 80'd0);
    tick;
    rst_n = 1'b1;
    #1;
    check_eq("midrst_after_valid", 80'(bus.rsp_valid), 80'd0);
    fetch("after_rst", 64'd64, 80'h20348553000000000000, 1'b0, 0, 1'b0);

    accept(64'd62);
    tick;
    tick;
    tick;
    load_en   = 1'b1;
    load_addr = 64'd65;
    load_data = 8'hFF;
    tick;
    load_en = 1'b0;
    ref_mem[65] = 8'hFF;
    wait_rsp("coll", lat);
    check_eq("coll_old_byte", 80'(bus.rsp_instruct[55:48]), 80'h34);
    complete("coll");
    fetch("coll_new", 64'd62, 80'h612320FF855300000000, 1'b0, 0, 1'b0);

    for (int i = 0; i < MEM_BYTES; i++) load_byte(64'(i), 8'($urandom));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) load_byte(64'(MEM_BYTES + $urandom_range(0, 2047)), 8'($urandom));
        else load_byte(64'($urandom_range(0, MEM_BYTES - 1)), 8'($urandom));
      end
      case ($urandom_range(0, 3))
        0: pc = 64'($urandom_range(0, MEM_BYTES - 11));
        1: pc = 64'($urandom_range(MEM_BYTES - 14, MEM_BYTES + 4));
        2: pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: pc = {32'($urandom), 32'($urandom)};
      endcase
      m = model(pc);
      fetch("rand", pc, m[79:0], m[80], $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
